serial_parity_checker: RTL and testbench
========================================

SERIAL_PARITY_CHECKER -- requirements
Module: serial_parity_checker

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 2..16.
REQ-002 Parameter ODD_PAR, default 0; 0 = even parity, 1 = odd parity.
REQ-003 clk  input  1  single clock; all state changes on its rising edge.
REQ-004 rst  input  1  reset; synchronous and active-high.
REQ-005 din  input  1  serial line bit; sampled only when din_vld=1.
REQ-006 din_vld  input  1  bit strobe; one line bit is consumed per cycle with din_vld=1.
REQ-007 data_out  output  DATA_W  last received data word, LSB-first reassembled.
REQ-008 data_vld  output  1  one-cycle pulse marking a completed frame.
REQ-009 par_err  output  1  parity mismatch for the frame flagged by data_vld.
REQ-010 frm_err  output  1  stop bit was 0 for the frame flagged by data_vld.
REQ-011 busy  output  1  high while a frame is in progress (any state other than IDLE).

Function
REQ-012 Frame format: 1 start bit (0), then DATA_W data bits LSB first, then 1 parity bit, then 1 stop bit (1).
REQ-013 FSM states: IDLE, DATA, PARITY, STOP.
REQ-014 IDLE: din_vld=1 with din=0 moves to DATA and clears the bit counter and parity accumulator; din_vld=1 with din=1 stays in IDLE (line idle).
REQ-015 DATA: each strobed bit shifts into bit position [count]; the parity accumulator XORs with din; count increments.
REQ-016 DATA moves to PARITY on the strobe carrying bit DATA_W-1; the counter is DATA_W-bit-index wide and never wraps past DATA_W-1.
REQ-017 PARITY: the strobed bit is stored as the received parity; mismatch = (acc ^ din) != ODD_PAR; moves to STOP.
REQ-018 STOP: the strobed bit is checked, and the FSM returns to IDLE.
REQ-019 The cycle after the STOP strobe: data_vld=1 for exactly one cycle; data_out takes the assembled word; par_err and frm_err take the frame's flags.
REQ-020 data_out, par_err and frm_err hold their values until the next data_vld; they do not change mid-frame.
REQ-021 A frame is delivered even when it has an error; errors are reported, not dropped.
REQ-022 Cycles with din_vld=0 leave all state unchanged in every state (gaps of any length are legal).
REQ-023 A start bit strobed in the same cycle that data_vld is asserted is accepted; back-to-back frames lose no bits.
REQ-024 Latency: data_vld rises 1 cycle after the STOP-bit strobe cycle.

Reset
REQ-025 Reset is sampled on the clk edge; with rst=1 the FSM goes to IDLE and counter, accumulator and shift register clear.
REQ-026 Reset values: data_out=0, data_vld=0, par_err=0, frm_err=0, busy=0.
REQ-027 rst during a frame discards the partial frame with no data_vld; rst has priority over din_vld in the same cycle.

Structure
REQ-028 The shared package serial_parity_pkg holds the state enum (IDLE, DATA, PARITY, STOP) and the default DATA_W constant.
REQ-029 One sub-module, parity_acc (clear, enable, bit in, running XOR out), is instantiated for the accumulator; the rest stays flat.
REQ-030 All outputs are driven from registers; there is no combinational path from din to any output.

Verification
REQ-031 Even mode, frame 0,10100101(LSB first = 0xA5),0,1 -> data_out=0xA5, data_vld pulse, par_err=0, frm_err=0.
REQ-032 Even mode, 0xA5 sent with parity bit 1 -> data_vld pulse, data_out=0xA5, par_err=1, frm_err=0.
REQ-033 ODD_PAR=1, 0x00 sent with parity 1 and stop 0 -> data_out=0x00, par_err=0, frm_err=1.
REQ-034 0x3C with random din_vld gaps of 0-5 cycles -> same result as the gap-free case; busy is high from the start strobe until the STOP strobe.
REQ-035 rst pulse after 4 data bits, then a full frame 0x81 -> only one data_vld, carrying data_out=0x81.
REQ-036 Two frames (0x12, 0x34) with no idle bits between them -> two data_vld pulses carrying 0x12 then 0x34, both with par_err=0.

Source files
------------

// File: rtl/serial_parity_checker_pkg.sv
// Shared types for the serial parity checker: FSM state encoding and default frame width.
package serial_parity_pkg;

    localparam int unsigned DEFAULT_DATA_W = 8;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DATA   = 2'd1,
        PARITY = 2'd2,
        STOP   = 2'd3
    } state_e;

endpackage

// File: rtl/serial_parity_checker_parity_acc.sv
// Running XOR of strobed serial bits; clear wins over enable.
module parity_acc (
    input  logic clk,
    input  logic rst,
    input  logic clr_i,
    input  logic en_i,
    input  logic bit_i,
    output logic acc_o
);

    logic acc_q;

    always_ff @(posedge clk) begin
        if (rst || clr_i) begin
            acc_q <= 1'b0;
        end else if (en_i) begin
            acc_q <= acc_q ^ bit_i;
        end
    end

    assign acc_o = acc_q;

endmodule

// File: rtl/serial_parity_checker.sv
// Receives start / DATA_W data bits LSB first / parity / stop frames on a strobed serial line
// and reports each completed word with its parity and framing flags.
module serial_parity_checker
    import serial_parity_pkg::*;
#(
    parameter int unsigned DATA_W  = DEFAULT_DATA_W,
    parameter int unsigned ODD_PAR = 0
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              din,
    input  logic              din_vld,
    output logic [DATA_W-1:0] data_out,
    output logic              data_vld,
    output logic              par_err,
    output logic              frm_err,
    output logic              busy
);

    localparam int unsigned        CNT_W    = (DATA_W > 1) ? $clog2(DATA_W) : 1;
    localparam logic [CNT_W-1:0]   LAST_IDX = CNT_W'(DATA_W - 1);
    localparam logic               ODD_BIT  = 1'(ODD_PAR);

    state_e              state_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [DATA_W-1:0]   shift_q;
    logic                perr_q;
    logic [DATA_W-1:0]   data_out_q;
    logic                data_vld_q;
    logic                par_err_q;
    logic                frm_err_q;
    logic                busy_q;
    logic                acc;
    logic                acc_clr_c;
    logic                acc_en_c;

    assign acc_clr_c = din_vld && (state_q == IDLE) && !din;
    assign acc_en_c  = din_vld && (state_q == DATA);

    parity_acc u_parity_acc (
        .clk   (clk),
        .rst   (rst),
        .clr_i (acc_clr_c),
        .en_i  (acc_en_c),
        .bit_i (din),
        .acc_o (acc)
    );

    // Frame FSM; result registers only move on the STOP strobe so they hold between frames.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            cnt_q      <= '0;
            shift_q    <= '0;
            perr_q     <= 1'b0;
            data_out_q <= '0;
            data_vld_q <= 1'b0;
            par_err_q  <= 1'b0;
            frm_err_q  <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            data_vld_q <= 1'b0;
            if (din_vld) begin
                case (state_q)
                    IDLE: begin
                        if (!din) begin
                            state_q <= DATA;
                            cnt_q   <= '0;
                            shift_q <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    DATA: begin
                        shift_q[cnt_q] <= din;
                        if (cnt_q == LAST_IDX) begin
                            state_q <= PARITY;
                        end else begin
                            cnt_q <= cnt_q + CNT_W'(1);
                        end
                    end
                    PARITY: begin
                        perr_q  <= ((acc ^ din) != ODD_BIT);
                        state_q <= STOP;
                    end
                    STOP: begin
                        state_q    <= IDLE;
                        busy_q     <= 1'b0;
                        data_vld_q <= 1'b1;
                        data_out_q <= shift_q;
                        par_err_q  <= perr_q;
                        frm_err_q  <= ~din;
                    end
                    default: begin
                        state_q <= IDLE;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign data_out = data_out_q;
    assign data_vld = data_vld_q;
    assign par_err  = par_err_q;
    assign frm_err  = frm_err_q;
    assign busy     = busy_q;

endmodule

// File: tb/tb_serial_parity_checker.sv
// Directed bench for serial_parity_checker: even-parity and odd-parity instances on a shared line.
module tb_serial_parity_checker;

    logic       clk = 1'b0;
    logic       rst;
    logic       din;
    logic       din_vld;

    logic [7:0] e_data;
    logic       e_vld, e_perr, e_ferr, e_busy;
    logic [7:0] o_data;
    logic       o_vld, o_perr, o_ferr, o_busy;

    int total = 0;
    int bad   = 0;

    int         vld_cnt = 0;
    logic [7:0] log_data[$];
    logic       log_perr[$];
    logic       log_ferr[$];

    always #5 clk = ~clk;

    serial_parity_checker #(.DATA_W(8), .ODD_PAR(0)) u_even (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
        .data_out(e_data), .data_vld(e_vld), .par_err(e_perr), .frm_err(e_ferr), .busy(e_busy)
    );

    serial_parity_checker #(.DATA_W(8), .ODD_PAR(1)) u_odd (
        .clk(clk), .rst(rst), .din(din), .din_vld(din_vld),
        .data_out(o_data), .data_vld(o_vld), .par_err(o_perr), .frm_err(o_ferr), .busy(o_busy)
    );

    // Record every completed frame from the even-parity instance.
    always @(negedge clk) begin
        if (e_vld === 1'b1) begin
            vld_cnt = vld_cnt + 1;
            log_data.push_back(e_data);
            log_perr.push_back(e_perr);
            log_ferr.push_back(e_ferr);
        end
    end

    task automatic strobe(input logic b);
        din     = b;
        din_vld = 1'b1;
        @(negedge clk);
        din_vld = 1'b0;
        din     = 1'b1;
    endtask

    task automatic gap(input int maxg);
        int n;
        n = (maxg > 0) ? int'($urandom_range(0, maxg)) : 0;
        repeat (n) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input logic p, input logic s, input int maxg);
        strobe(1'b0);
        for (int i = 0; i < 8; i++) begin
            gap(maxg);
            strobe(d[i]);
        end
        gap(maxg);
        strobe(p);
        gap(maxg);
        strobe(s);
    endtask

    task automatic test_reset();
        rst = 1'b1; din = 1'b0; din_vld = 1'b1;
        repeat (2) @(negedge clk);
        din_vld = 1'b0; din = 1'b1; rst = 1'b0;
        @(negedge clk);
        total++; if (e_data !== 8'h00) begin bad++; $display("FAIL reset_data: got %h want 00", e_data); end
        total++; if (e_vld !== 1'b0) begin bad++; $display("FAIL reset_vld: got %b want 0", e_vld); end
        total++; if (e_perr !== 1'b0) begin bad++; $display("FAIL reset_perr: got %b want 0", e_perr); end
        total++; if (e_ferr !== 1'b0) begin bad++; $display("FAIL reset_ferr: got %b want 0", e_ferr); end
        total++; if (e_busy !== 1'b0) begin bad++; $display("FAIL reset_busy: got %b want 0", e_busy); end
        total++; if (o_busy !== 1'b0) begin bad++; $display("FAIL reset_obusy: got %b want 0", o_busy); end
    endtask

    task automatic test_idle_ones();
        int c0;
        c0 = vld_cnt;
        repeat (3) strobe(1'b1);
        total++; if (e_busy !== 1'b0) begin bad++; $display("FAIL idle_busy: got %b want 0", e_busy); end
        @(negedge clk);
        total++; if (vld_cnt != c0) begin bad++; $display("FAIL idle_vld: got %0d frames want 0", vld_cnt - c0); end
    endtask

    task automatic test_good_frame();
        send_frame(8'hA5, 1'b0, 1'b1, 0);
        total++; if (e_vld !== 1'b1) begin bad++; $display("FAIL good_vld: got %b want 1", e_vld); end
        total++; if (e_data !== 8'hA5) begin bad++; $display("FAIL good_data: got %h want a5", e_data); end
        total++; if (e_perr !== 1'b0) begin bad++; $display("FAIL good_perr: got %b want 0", e_perr); end
        total++; if (e_ferr !== 1'b0) begin bad++; $display("FAIL good_ferr: got %b want 0", e_ferr); end
        total++; if (e_busy !== 1'b0) begin bad++; $display("FAIL good_busy: got %b want 0", e_busy); end
        @(negedge clk);
        total++; if (e_vld !== 1'b0) begin bad++; $display("FAIL good_pulse: got %b want 0", e_vld); end
        total++; if (e_data !== 8'hA5) begin bad++; $display("FAIL good_hold: got %h want a5", e_data); end
    endtask

    task automatic test_par_err();
        send_frame(8'hA5, 1'b1, 1'b1, 0);
        total++; if (e_vld !== 1'b1) begin bad++; $display("FAIL perr_vld: got %b want 1", e_vld); end
        total++; if (e_data !== 8'hA5) begin bad++; $display("FAIL perr_data: got %h want a5", e_data); end
        total++; if (e_perr !== 1'b1) begin bad++; $display("FAIL perr_flag: got %b want 1", e_perr); end
        total++; if (e_ferr !== 1'b0) begin bad++; $display("FAIL perr_ferr: got %b want 0", e_ferr); end
        total++; if (o_perr !== 1'b0) begin bad++; $display("FAIL perr_odd: got %b want 0", o_perr); end
        @(negedge clk);
    endtask

    task automatic test_odd_frm_err();
        send_frame(8'h00, 1'b1, 1'b0, 0);
        total++; if (o_vld !== 1'b1) begin bad++; $display("FAIL odd_vld: got %b want 1", o_vld); end
        total++; if (o_data !== 8'h00) begin bad++; $display("FAIL odd_data: got %h want 00", o_data); end
        total++; if (o_perr !== 1'b0) begin bad++; $display("FAIL odd_perr: got %b want 0", o_perr); end
        total++; if (o_ferr !== 1'b1) begin bad++; $display("FAIL odd_ferr: got %b want 1", o_ferr); end
        total++; if (e_perr !== 1'b1) begin bad++; $display("FAIL odd_even_perr: got %b want 1", e_perr); end
        @(negedge clk);
    endtask

    task automatic test_gaps();
        logic [7:0] d;
        d = 8'h3C;
        strobe(1'b0);
        total++; if (e_busy !== 1'b1) begin bad++; $display("FAIL gap_busy_start: got %b want 1", e_busy); end
        for (int i = 0; i < 8; i++) begin
            gap(5);
            total++; if (e_data !== 8'h00) begin bad++; $display("FAIL gap_hold_%0d: got %h want 00", i, e_data); end
            strobe(d[i]);
            total++; if (e_busy !== 1'b1) begin bad++; $display("FAIL gap_busy_%0d: got %b want 1", i, e_busy); end
        end
        gap(5);
        strobe(1'b0);
        gap(5);
        total++; if (e_vld !== 1'b0) begin bad++; $display("FAIL gap_early_vld: got %b want 0", e_vld); end
        strobe(1'b1);
        total++; if (e_vld !== 1'b1) begin bad++; $display("FAIL gap_vld: got %b want 1", e_vld); end
        total++; if (e_data !== 8'h3C) begin bad++; $display("FAIL gap_data: got %h want 3c", e_data); end
        total++; if (e_perr !== 1'b0) begin bad++; $display("FAIL gap_perr: got %b want 0", e_perr); end
        total++; if (e_ferr !== 1'b0) begin bad++; $display("FAIL gap_ferr: got %b want 0", e_ferr); end
        total++; if (e_busy !== 1'b0) begin bad++; $display("FAIL gap_busy_end: got %b want 0", e_busy); end
        @(negedge clk);
    endtask

    task automatic test_reset_mid();
        int c0;
        int n0;
        c0 = vld_cnt;
        n0 = log_data.size();
        strobe(1'b0);
        repeat (4) strobe(1'b1);
        rst = 1'b1; din = 1'b1; din_vld = 1'b1;
        @(negedge clk);
        rst = 1'b0; din_vld = 1'b0;
        total++; if (e_busy !== 1'b0) begin bad++; $display("FAIL rstmid_busy: got %b want 0", e_busy); end
        send_frame(8'h81, 1'b0, 1'b1, 2);
        repeat (2) @(negedge clk);
        total++; if (vld_cnt - c0 != 1) begin bad++; $display("FAIL rstmid_count: got %0d want 1", vld_cnt - c0); end
        if (log_data.size() > n0) begin
            total++; if (log_data[n0] !== 8'h81) begin bad++; $display("FAIL rstmid_data: got %h want 81", log_data[n0]); end
            total++; if (log_perr[n0] !== 1'b0) begin bad++; $display("FAIL rstmid_perr: got %b want 0", log_perr[n0]); end
        end
    endtask

    task automatic test_back_to_back();
        int c0;
        int n0;
        c0 = vld_cnt;
        n0 = log_data.size();
        send_frame(8'h12, 1'b0, 1'b1, 0);
        total++; if (e_vld !== 1'b1) begin bad++; $display("FAIL b2b_vld1: got %b want 1", e_vld); end
        send_frame(8'h34, 1'b1, 1'b1, 0);
        repeat (2) @(negedge clk);
        total++; if (vld_cnt - c0 != 2) begin bad++; $display("FAIL b2b_count: got %0d want 2", vld_cnt - c0); end
        if (log_data.size() >= n0 + 2) begin
            total++; if (log_data[n0] !== 8'h12) begin bad++; $display("FAIL b2b_data1: got %h want 12", log_data[n0]); end
            total++; if (log_data[n0+1] !== 8'h34) begin bad++; $display("FAIL b2b_data2: got %h want 34", log_data[n0+1]); end
            total++; if (log_perr[n0] !== 1'b0) begin bad++; $display("FAIL b2b_perr1: got %b want 0", log_perr[n0]); end
            total++; if (log_perr[n0+1] !== 1'b0) begin bad++; $display("FAIL b2b_perr2: got %b want 0", log_perr[n0+1]); end
            total++; if (log_ferr[n0+1] !== 1'b0) begin bad++; $display("FAIL b2b_ferr2: got %b want 0", log_ferr[n0+1]); end
        end
    endtask

    initial begin
        rst = 1'b1; din = 1'b1; din_vld = 1'b0;
        @(negedge clk);
        test_reset();
        test_idle_ones();
        test_good_frame();
        test_par_err();
        test_odd_frm_err();
        test_gaps();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
